sm_accumulator: RTL and testbench
=================================

Name: sm_accumulator

Overview:
Streaming sign-magnitude fixed-point accumulator for the equalizer datapath. It sums ACC_LEN consecutive input samples per frame and emits one registered frame sum, using sign-magnitude arithmetic throughout. Input and output use valid/ready handshakes. It sits after the tap multipliers and replaces chains of combinational adders with one sequential adder.

Parameters:
N, 16, total bits per word: bit N-1 is the sign, bits N-2:0 are the magnitude.
ACC_LEN, 8, samples per frame; must be at least 2.
CNT_W, $clog2(ACC_LEN), width of the frame counter (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous reset, active-low.
clear  input  1  synchronous frame abort.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a sample.
in_data  input  N  sign-magnitude sample.
out_valid  output  1  frame sum is available.
out_ready  input  1  downstream accepts the sum.
out_data  output  N  sign-magnitude frame sum.
out_sat  output  1  saturation occurred during this frame.

Behaviour:
- Reset (rst_n low, asynchronous): acc=0, cnt=0, sat_sticky=0, out_valid=0, out_data=0, out_sat=0. in_ready is 1 after release.
- Handshakes:
  - A sample is accepted when in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready). This is combinational from out_ready; there is no skid buffer.
  - The output is consumed when out_valid && out_ready.
- Add rule, sum = sm_add(acc, x):
  - Same signs: magnitudes are added and the sign is kept.
  - Different signs: the smaller magnitude is subtracted from the larger, and the sign of the larger operand is taken.
  - Equal magnitudes with different signs give +0.
  - Any zero result has sign 0. Negative zero is never produced.
  - An input of -0 (0x8000 for N=16) is treated as +0.
- Overflow: a magnitude carry out of bit N-2 is handled per the optional feature below.
- Frame sequencing:
  - The first accepted sample of a frame (cnt==0) loads acc = normalised x.
  - Later samples set acc = sm_add(acc, x) and cnt increments.
  - On the ACC_LEN-th accepted sample, in the same edge: out_data = sm_add(acc, x), out_sat = sat_sticky OR this add's overflow, out_valid=1, cnt=0, sat_sticky=0.
  - Latency: out_valid rises 1 cycle after the final sample is accepted.
  - Throughput: 1 sample per cycle while out_ready stays high.
- Output hold: out_data and out_sat are stable while out_valid && !out_ready.
  - A consume and a new frame completion in the same cycle is legal; out_valid stays 1 and the new data loads.
  - A consume with no completion clears out_valid.
- clear:
  - Sets cnt=0, acc=0, sat_sticky=0.
  - Does not touch a pending output.
  - If clear and an accepted sample occur in the same cycle, that sample becomes sample 1 of a new frame.
- Reset mid-frame discards the partial sum. Reset while out_valid is high drops the pending output.
- The frame counter wraps ACC_LEN-1 -> 0 only on an accepted sample. It never wraps on idle cycles.

Optional Feature:
SM_ACC_SAT_EN
- Defined:
  - On magnitude overflow, the magnitude clamps to 2^(N-1)-1 and the sign of the same-signed operands is kept.
  - Accumulation continues from the clamped value.
  - sat_sticky is set.
- Undefined:
  - The magnitude wraps modulo 2^(N-1) and the sign is kept.
  - If the wrapped magnitude is 0, the sign is forced to 0.
  - out_sat is tied to 0, and the sat_sticky register is not built.

Decomposition:
- Package sm_pkg holds:
  - localparam SIGN_POS helper;
  - function sm_norm, which maps -0 to +0;
  - an enum for add-result status {ADD_OK, ADD_OVF}.
- Sub-module sm_add_core (parameter N) is purely combinational.
  - Inputs: a, b. Outputs: sum, ovf.
  - It is instantiated once in the accumulator and is reusable by other datapath blocks.

Test Plan:
All cases use N=16, ACC_LEN=4.
- Mixed signs: samples 0x0005, 0x8003, 0x8002, 0x0001 with out_ready=1 -> one cycle after the 4th sample, out_valid=1, out_data=0x0001, out_sat=0.
- Cancellation to zero: 0x0007, 0x8007, 0x8000, 0x0000 -> out_data=0x0000, never 0x8000.
- Saturation with SM_ACC_SAT_EN defined: 0x7FFF, 0x0001, 0x8002, 0x0000 -> out_data=0x7FFD, out_sat=1. Without the macro: 0x7FFF+0x0001 wraps to magnitude 0 with sign 0, then -2 gives 0x8002, so out_data=0x8002 and out_sat=0.
- Backpressure: out_ready=0 while two frames are streamed -> first sum is held stable, in_ready drops after frame 1 completes, no sample is lost. Raising out_ready delivers both sums in order.
- clear after 2 samples of {0x0003, 0x0004}, then 4 samples of 0x0001 -> out_data=0x0004. A clear coincident with an accepted sample counts that sample as sample 1.
- Reset: assert rst_n=0 asynchronously mid-frame and while out_valid=1 -> all outputs are 0 immediately. The next 4 samples of 0x8001 give out_data=0x8004.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared sign-magnitude helpers for the equalizer datapath.
package sm_pkg;

  localparam int SIGN_POS = 15;

  typedef enum logic {
    ADD_OK  = 1'b0,
    ADD_OVF = 1'b1
  } add_status_t;

  // Maps -0 to +0 for any word width n <= 64 (word is zero-extended into x).
  function automatic logic [63:0] sm_norm(input logic [63:0] x, input int unsigned n);
    logic [63:0] mag_mask;
    mag_mask = (64'd1 << (n - 1)) - 64'd1;
    return ((x & mag_mask) == 64'd0) ? 64'd0 : x;
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder, never produces -0.
// SM_ACC_SAT_EN selects clamping instead of modulo wrap on magnitude overflow.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int N = SIGN_POS + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);

  localparam int M = N - 1;

  logic [N-1:0] w_a_n;
  logic [N-1:0] w_b_n;
  logic         w_sa;
  logic         w_sb;
  logic [M-1:0] w_ma;
  logic [M-1:0] w_mb;
  logic [M:0]   w_mag_sum;
  logic         w_a_ge;
  logic [M-1:0] w_diff;
  logic [M-1:0] w_mag;
  logic         w_sgn;
  add_status_t  w_status;

  assign w_a_n     = N'(sm_norm(64'(a), N));
  assign w_b_n     = N'(sm_norm(64'(b), N));
  assign w_sa      = w_a_n[M];
  assign w_sb      = w_b_n[M];
  assign w_ma      = w_a_n[M-1:0];
  assign w_mb      = w_b_n[M-1:0];
  assign w_mag_sum = {1'b0, w_ma} + {1'b0, w_mb};
  assign w_a_ge    = (w_ma >= w_mb);
  assign w_diff    = w_a_ge ? (w_ma - w_mb) : (w_mb - w_ma);

  always_comb begin
    w_status = ADD_OK;
    w_mag    = '0;
    w_sgn    = 1'b0;
    if (w_sa == w_sb) begin
      w_sgn = w_sa;
      w_mag = w_mag_sum[M-1:0];
      if (w_mag_sum[M]) begin
        w_status = ADD_OVF;
`ifdef SM_ACC_SAT_EN
        w_mag = {M{1'b1}};
`endif
      end
    end else begin
      w_mag = w_diff;
      w_sgn = w_a_ge ? w_sa : w_sb;
    end
    // A zero magnitude (cancellation or wrap) is always reported as +0.
    if (w_mag == '0) begin
      w_sgn = 1'b0;
    end
  end

  assign sum = {w_sgn, w_mag};
  assign ovf = (w_status == ADD_OVF);

endmodule

// File: rtl/sm_accumulator.sv
// Streaming sign-magnitude frame accumulator with valid/ready on both sides.
// SM_ACC_SAT_EN enables clamping on overflow and the sticky out_sat flag.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int N       = SIGN_POS + 1,
  parameter int ACC_LEN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  logic [N-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [N-1:0]     r_out_data;

  logic             w_accept;
  logic             w_consume;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_last;
  logic [N-1:0]     w_add_a;
  logic [N-1:0]     w_sum;
  logic             w_ovf;

  assign in_ready   = !(r_out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_consume  = r_out_valid && out_ready;
  // clear restarts the frame in the same cycle, so a coincident sample is sample 1.
  assign w_cnt_base = clear ? '0 : r_cnt;
  assign w_add_a    = (w_cnt_base == '0) ? '0 : r_acc;
  assign w_last     = w_accept && (w_cnt_base == LAST_CNT);

  sm_add_core #(.N(N)) u_add (
    .a   (w_add_a),
    .b   (in_data),
    .sum (w_sum),
    .ovf (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_base + 1'b1;
        end
      end else if (clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sum;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef SM_ACC_SAT_EN
  logic r_sat_sticky;
  logic r_out_sat;
  logic w_sticky_base;

  assign w_sticky_base = clear ? 1'b0 : r_sat_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_sticky <= 1'b0;
      r_out_sat    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_sat_sticky <= 1'b0;
          r_out_sat    <= w_sticky_base | w_ovf;
        end else begin
          r_sat_sticky <= w_sticky_base | w_ovf;
        end
      end else if (clear) begin
        r_sat_sticky <= 1'b0;
      end
    end
  end

  assign out_sat = r_out_sat;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = w_ovf;
  assign out_sat      = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_sm_accumulator.sv
// Randomized and directed bench for sm_accumulator against an integer-arithmetic frame model.
module tb_sm_accumulator;

  localparam int N       = 16;
  localparam int ACC_LEN = 4;
  localparam int MAXM    = 32767;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_data;
  logic          out_sat;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  // Model state: running signed value, samples so far, sticky flag, pending output.
  int          m_acc = 0;
  int          m_cnt = 0;
  bit          m_sticky = 1'b0;
  bit          m_valid = 1'b0;
  logic [15:0] m_data = '0;
  bit          m_sat = 1'b0;

  sm_accumulator #(.N(N), .ACC_LEN(ACC_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sm2int(input logic [15:0] x);
    int mag;
    mag = int'(x[14:0]);
    return x[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] int2sm(input int v);
    logic [15:0] r;
    if (v < 0) r = {1'b1, 15'(-v)};
    else       r = {1'b0, 15'(v)};
    return r;
  endfunction

  // Exact integer sum, then clamp or wrap the magnitude into 15 bits.
  task automatic model_add(input int a, input int b, output int r, output bit ov);
    int s;
    s  = a + b;
    ov = 1'b0;
    r  = s;
    if (s > MAXM) begin
      ov = 1'b1;
`ifdef SM_ACC_SAT_EN
      r = MAXM;
`else
      r = s - (MAXM + 1);
`endif
    end else if (s < -MAXM) begin
      ov = 1'b1;
`ifdef SM_ACC_SAT_EN
      r = -MAXM;
`else
      r = s + (MAXM + 1);
`endif
    end
  endtask

  task automatic step(output bit accepted);
    int b_acc, b_cnt, r;
    bit b_st, ov, cons, emit;
    int n_acc, n_cnt;
    bit n_st, n_valid, n_sat;
    logic [15:0] n_data;
    accepted = in_valid && !(m_valid && !out_ready);
    cons     = m_valid && out_ready;
    b_acc = clear ? 0 : m_acc;
    b_cnt = clear ? 0 : m_cnt;
    b_st  = clear ? 1'b0 : m_sticky;
    n_acc = b_acc; n_cnt = b_cnt; n_st = b_st;
    n_valid = m_valid; n_data = m_data; n_sat = m_sat;
    emit = 1'b0;
    if (accepted) begin
      model_add((b_cnt == 0) ? 0 : b_acc, sm2int(in_data), r, ov);
      if (b_cnt == ACC_LEN - 1) begin
        emit = 1'b1;
        n_valid = 1'b1;
        n_data  = int2sm(r);
`ifdef SM_ACC_SAT_EN
        n_sat = b_st | ov;
`else
        n_sat = 1'b0;
`endif
        n_acc = 0; n_cnt = 0; n_st = 1'b0;
      end else begin
        n_acc = r; n_cnt = b_cnt + 1; n_st = b_st | ov;
      end
    end
    if (cons && !emit) n_valid = 1'b0;
    if (cons) $display("frame consumed: data=%h sat=%0b", m_data, m_sat);
    @(posedge clk);
    m_acc = n_acc; m_cnt = n_cnt; m_sticky = n_st;
    m_valid = n_valid; m_data = n_data; m_sat = n_sat;
    #1;
  endtask

  task automatic send(input logic [15:0] x, input bit clr);
    bit a;
    a = 1'b0;
    in_valid = 1'b1; in_data = x; clear = clr;
    for (int k = 0; k < 50 && !a; k++) step(a);
    in_valid = 1'b0; clear = 1'b0;
    chk("send_accept", 32'(a), 32'd1);
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    repeat (n) step(a);
  endtask

  task automatic frame_chk(input string nm, input logic [15:0] d, input bit s);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, 32'(out_data), 32'(d));
    chk({nm, "_sat"}, 32'(out_sat), 32'(s));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    m_acc = 0; m_cnt = 0; m_sticky = 1'b0;
    m_valid = 1'b0; m_data = '0; m_sat = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("in_ready", 32'(in_ready), 32'(!(m_valid && !out_ready)));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_sat", 32'(out_sat), 32'(m_sat));
      end
    end
  end

  initial begin
    bit a;
    logic [15:0] x;
    #3;
    do_reset();
    cmp_en = 1'b1;
    out_ready = 1'b1;

    send(16'h0005, 0); send(16'h8003, 0); send(16'h8002, 0); send(16'h0001, 0);
    frame_chk("mixed", 16'h0001, 1'b0);
    idle(1);

    send(16'h0007, 0); send(16'h8007, 0); send(16'h8000, 0); send(16'h0000, 0);
    frame_chk("cancel", 16'h0000, 1'b0);
    idle(1);

    send(16'h7FFF, 0); send(16'h0001, 0); send(16'h8002, 0); send(16'h0000, 0);
`ifdef SM_ACC_SAT_EN
    frame_chk("sat", 16'h7FFD, 1'b1);
`else
    frame_chk("wrap", 16'h8002, 1'b0);
`endif
    idle(1);

    send(16'h0003, 0); send(16'h0004, 0);
    clear = 1'b1; idle(1); clear = 1'b0;
    repeat (4) send(16'h0001, 0);
    frame_chk("clear", 16'h0004, 1'b0);
    idle(1);

    send(16'h0003, 0); send(16'h0004, 0); send(16'h0002, 1);
    repeat (3) send(16'h0001, 0);
    frame_chk("clear_coinc", 16'h0005, 1'b0);
    idle(1);

    out_ready = 1'b0;
    repeat (4) send(16'h0010, 0);
    frame_chk("bp1", 16'h0040, 1'b0);
    in_valid = 1'b1; in_data = 16'h0020;
    repeat (3) begin
      step(a);
      chk("bp_blocked", 32'(a), 32'd0);
      chk("bp_hold", 32'(out_data), 32'h0040);
    end
    out_ready = 1'b1;
    step(a);
    chk("bp_release_accept", 32'(a), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) send(16'h0020, 0);
    frame_chk("bp2", 16'h0080, 1'b0);
    out_ready = 1'b1;
    idle(1);
    chk("bp_drained", 32'(out_valid), 32'd0);

    send(16'h0001, 0); send(16'h0001, 0);
    do_reset();
    out_ready = 1'b0;
    repeat (4) send(16'h0001, 0);
    frame_chk("pre_rst", 16'h0004, 1'b0);
    do_reset();
    out_ready = 1'b1;
    repeat (4) send(16'h8001, 0);
    frame_chk("post_rst", 16'h8004, 1'b0);
    idle(1);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: x = 16'h7FFF;
        1: x = 16'hFFFF;
        2: x = 16'h8000;
        3: x = 16'h0000;
        default: x = 16'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = x;
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 19) == 0);
      step(a);
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
